// File: rtl/accel_filter.sv
// accel_filter: three-axis moving-average filter for accelerometer samples.
// One shared adder updates the X, Y and Z running sums on consecutive cycles,
// then all three averages are published together with a one-cycle out_valid.
// Optional feature macro: ACCEL_FILTER_BYPASS_EN adds a 'bypass' input that
// publishes the raw held samples instead of the averages, while the window
// history keeps updating so averaging resumes correctly when bypass drops.
module accel_filter #(
    parameter int LOG2_TAPS = 3,
    parameter int DATA_W    = 16
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
`ifdef ACCEL_FILTER_BYPASS_EN
    input  logic                 bypass,
`endif
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_x,
    input  logic [DATA_W-1:0]    in_y,
    input  logic [DATA_W-1:0]    in_z,
    output logic [DATA_W-1:0]    filter_x,
    output logic [DATA_W-1:0]    filter_y,
    output logic [DATA_W-1:0]    filter_z,
    output logic                 out_valid,
    output logic [LOG2_TAPS:0]   sample_count
);

    localparam int TAPS  = 1 << LOG2_TAPS;
    localparam int SUM_W = DATA_W + LOG2_TAPS;
    localparam logic [LOG2_TAPS:0] COUNT_MAX = (LOG2_TAPS+1)'(TAPS);

    typedef enum logic [2:0] {
        IDLE,
        AX_X,
        AX_Y,
        AX_Z,
        PUBLISH
    } state_t;

    state_t                   state;
    logic [DATA_W-1:0]        hist_x [TAPS];
    logic [DATA_W-1:0]        hist_y [TAPS];
    logic [DATA_W-1:0]        hist_z [TAPS];
    logic signed [SUM_W-1:0]  sum_x, sum_y, sum_z;
    logic [DATA_W-1:0]        held_x, held_y, held_z;
    logic [LOG2_TAPS-1:0]     wptr;

    // Shared adder operands, selected by the axis currently being processed
    logic signed [SUM_W-1:0]  acc_old;
    logic signed [SUM_W-1:0]  acc_new;
    logic [DATA_W-1:0]        evict;
    logic [DATA_W-1:0]        fresh;

    // Sign-extend a sample to running-sum width
    function automatic logic signed [SUM_W-1:0] sext(input logic [DATA_W-1:0] v);
        return {{LOG2_TAPS{v[DATA_W-1]}}, v};
    endfunction

    // Window average: arithmetic shift floors toward -infinity, no rounding
    function automatic logic [DATA_W-1:0] window_avg(input logic signed [SUM_W-1:0] s);
        return DATA_W'(s >>> LOG2_TAPS);
    endfunction

    // Operand mux and shared adder: new sum = old sum - evicted entry + new sample
    always_comb begin
        // NOTE: every output of this block gets a default first, so states
        // that do not use the adder cannot leave a latch behind.
        acc_old = '0;
        evict   = '0;
        fresh   = '0;
        case (state)
            AX_X: begin
                acc_old = sum_x;
                evict   = hist_x[wptr];
                fresh   = held_x;
            end
            AX_Y: begin
                acc_old = sum_y;
                evict   = hist_y[wptr];
                fresh   = held_y;
            end
            AX_Z: begin
                acc_old = sum_z;
                evict   = hist_z[wptr];
                fresh   = held_z;
            end
            default: ;
        endcase
        acc_new = acc_old - sext(evict) + sext(fresh);
    end

    // Sequencer, window storage and registered outputs
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state        <= IDLE;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            filter_x     <= '0;
            filter_y     <= '0;
            filter_z     <= '0;
            sample_count <= '0;
            wptr         <= '0;
            sum_x        <= '0;
            sum_y        <= '0;
            sum_z        <= '0;
            held_x       <= '0;
            held_y       <= '0;
            held_z       <= '0;
            // NOTE: the history is cleared on reset on purpose: warm-up relies
            // on unwritten entries being zero, so the evicted value is always
            // correct without a separate fill counter.
            for (int i = 0; i < TAPS; i++) begin
                hist_x[i] <= '0;
                hist_y[i] <= '0;
                hist_z[i] <= '0;
            end
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // read in this block sees the value from before this edge.
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        held_x   <= in_x;
                        held_y   <= in_y;
                        held_z   <= in_z;
                        in_ready <= 1'b0;
                        state    <= AX_X;
                    end
                end
                AX_X: begin
                    sum_x        <= acc_new;
                    hist_x[wptr] <= held_x;
                    state        <= AX_Y;
                end
                AX_Y: begin
                    sum_y        <= acc_new;
                    hist_y[wptr] <= held_y;
                    state        <= AX_Z;
                end
                AX_Z: begin
                    // Outputs are loaded on entry to PUBLISH so they are valid
                    // in the same cycle as the out_valid pulse; Z uses the
                    // adder result directly since sum_z updates on this edge.
                    sum_z        <= acc_new;
                    hist_z[wptr] <= held_z;
`ifdef ACCEL_FILTER_BYPASS_EN
                    if (bypass) begin
                        filter_x <= held_x;
                        filter_y <= held_y;
                        filter_z <= held_z;
                    end else begin
                        filter_x <= window_avg(sum_x);
                        filter_y <= window_avg(sum_y);
                        filter_z <= window_avg(acc_new);
                    end
`else
                    filter_x     <= window_avg(sum_x);
                    filter_y     <= window_avg(sum_y);
                    filter_z     <= window_avg(acc_new);
`endif
                    out_valid    <= 1'b1;
                    state        <= PUBLISH;
                end
                PUBLISH: begin
                    wptr <= wptr + 1'b1;
                    if (sample_count < COUNT_MAX) begin
                        sample_count <= sample_count + 1'b1;
                    end
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accel_filter.sv
// Self-checking bench for accel_filter: randomized and directed triples are
// compared against a window-average model built from per-axis sample queues.
module tb_accel_filter;

    localparam int LOG2_TAPS = 3;
    localparam int DATA_W    = 16;
    localparam int TAPS      = 1 << LOG2_TAPS;

    logic                clk_clk = 1'b0;
    logic                reset_reset;
`ifdef ACCEL_FILTER_BYPASS_EN
    logic                bypass;
`endif
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   in_x, in_y, in_z;
    logic [DATA_W-1:0]   filter_x, filter_y, filter_z;
    logic                out_valid;
    logic [LOG2_TAPS:0]  sample_count;

    int checks = 0;
    int errors = 0;

    // Reference model: every accepted sample since reset, per axis
    int qx[$];
    int qy[$];
    int qz[$];

    always #5 clk_clk = ~clk_clk;

    accel_filter #(
        .LOG2_TAPS(LOG2_TAPS),
        .DATA_W   (DATA_W)
    ) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
`ifdef ACCEL_FILTER_BYPASS_EN
        .bypass      (bypass),
`endif
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_z        (in_z),
        .filter_x    (filter_x),
        .filter_y    (filter_y),
        .filter_z    (filter_z),
        .out_valid   (out_valid),
        .sample_count(sample_count)
    );

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Mean of the last TAPS samples (missing ones count as zero), floored
    function automatic int win_avg(input int q[$]);
        int s;
        int lo;
        s  = 0;
        lo = (q.size() > TAPS) ? q.size() - TAPS : 0;
        for (int i = lo; i < q.size(); i++) s += q[i];
        if (s >= 0) return s / TAPS;
        return -((-s + TAPS - 1) / TAPS);
    endfunction

    function automatic int rnd16();
        logic signed [15:0] v;
        v = 16'($urandom);
        return int'(v);
    endfunction

    task automatic do_reset();
        reset_reset = 1'b1;
        repeat (2) @(negedge clk_clk);
        reset_reset = 1'b0;
        qx.delete();
        qy.delete();
        qz.delete();
    endtask

    // Send one triple and follow it through the five-cycle transaction.
    // glitch: drive a different triple during AX_Y, which must be ignored.
    // keep_valid: leave in_valid high so the next triple follows back-to-back.
    task automatic run_triple(input int x, input int y, input int z,
                              input bit glitch, input bit keep_valid, input bit byp);
        int n;
        int ex, ey, ez;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk_clk);
            n++;
        end
        check("ready_before_accept", in_ready, 1);
        in_x     = x[DATA_W-1:0];
        in_y     = y[DATA_W-1:0];
        in_z     = z[DATA_W-1:0];
        in_valid = 1'b1;
        qx.push_back(x);
        qy.push_back(y);
        qz.push_back(z);
        ex = byp ? x : win_avg(qx);
        ey = byp ? y : win_avg(qy);
        ez = byp ? z : win_avg(qz);
        @(negedge clk_clk);
        if (!keep_valid) in_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i > 1) @(negedge clk_clk);
            check($sformatf("in_ready_c%0d", i), in_ready, (i == 5) ? 1 : 0);
            check($sformatf("out_valid_c%0d", i), out_valid, (i == 4) ? 1 : 0);
            if (i == 4) begin
                check("filter_x", $signed(filter_x), ex);
                check("filter_y", $signed(filter_y), ey);
                check("filter_z", $signed(filter_z), ez);
            end
            if (i == 5) begin
                check("sample_count", sample_count, (qx.size() < TAPS) ? qx.size() : TAPS);
                check("filter_x_held", $signed(filter_x), ex);
            end
            if (glitch && i == 2) begin
                in_x     = 16'(rnd16());
                in_y     = 16'(rnd16());
                in_z     = 16'(rnd16());
                in_valid = 1'b1;
            end
            if (glitch && i == 3 && !keep_valid) in_valid = 1'b0;
        end
    endtask

    initial begin
        in_valid = 1'b0;
        in_x     = '0;
        in_y     = '0;
        in_z     = '0;
`ifdef ACCEL_FILTER_BYPASS_EN
        bypass   = 1'b0;
`endif
        do_reset();

        // Reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_filter_x", filter_x, 0);
        check("rst_filter_y", filter_y, 0);
        check("rst_filter_z", filter_z, 0);
        check("rst_sample_count", sample_count, 0);

        // Single triple after reset: (800,-16,-1) -> (100,-2,-1)
        run_triple(800, -16, -1, 1'b0, 1'b0, 1'b0);

        // Eight back-to-back triples with in_valid held high
        do_reset();
        for (int k = 0; k < 8; k++) run_triple(800, 800, 800, 1'b0, (k < 7), 1'b0);

        // Eviction and pointer wrap: 8x1000 then 8x0 on X
        do_reset();
        for (int k = 0; k < 8; k++) run_triple(1000, rnd16(), rnd16(), 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) run_triple(0, rnd16(), rnd16(), 1'b0, 1'b0, 1'b0);

        // Full-scale window on every axis
        do_reset();
        for (int k = 0; k < 8; k++) run_triple(32767, -32768, 32767, 1'b0, 1'b0, 1'b0);

        // Input driven during AX_Y must be ignored
        run_triple(rnd16(), rnd16(), rnd16(), 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_clk);
            check("no_extra_out_valid", out_valid, 0);
        end

        // Random mixed-sign traffic, including ignored glitches
        for (int k = 0; k < 14; k++)
            run_triple(rnd16(), rnd16(), rnd16(), ($urandom_range(0, 3) == 0), 1'b0, 1'b0);

        // Reset in the middle of a transaction clears history
        do_reset();
        for (int k = 0; k < 4; k++) run_triple(400, 400, 400, 1'b0, 1'b0, 1'b0);
        in_x     = 16'(999);
        in_y     = 16'(999);
        in_z     = 16'(999);
        in_valid = 1'b1;
        @(negedge clk_clk);
        in_valid = 1'b0;
        @(negedge clk_clk);
        reset_reset = 1'b1;
        @(negedge clk_clk);
        reset_reset = 1'b0;
        qx.delete();
        qy.delete();
        qz.delete();
        check("midrst_in_ready", in_ready, 1);
        check("midrst_filter_x", filter_x, 0);
        check("midrst_sample_count", sample_count, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_clk);
            check("midrst_no_out_valid", out_valid, 0);
        end
        run_triple(400, 400, 400, 1'b0, 1'b0, 1'b0);

`ifdef ACCEL_FILTER_BYPASS_EN
        // Bypass publishes raw samples; averaging resumes once it drops
        bypass = 1'b1;
        run_triple(1234, rnd16(), rnd16(), 1'b0, 1'b0, 1'b1);
        run_triple(rnd16(), rnd16(), rnd16(), 1'b0, 1'b0, 1'b1);
        bypass = 1'b0;
        run_triple(rnd16(), rnd16(), rnd16(), 1'b0, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
